i2c_byte_uart_tx: RTL and testbench

//   Downstream of the I2C decoder. Buffers decoded bytes (one-cycle data/valid pulses, no back-pressure) in a small FIFO.

---
 rtl/i2c_byte_uart_tx.sv | 126 ++++++++++++
 tb/tb_i2c_byte_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_uart_tx.sv
// Byte FIFO fed by single-cycle decoder strobes, drained by a UART 8N1 serialiser.
// Dropped bytes (push into a full FIFO with no pop that cycle) raise a sticky overflow flag.
module i2c_byte_uart_tx #(
   parameter int CLK_DIV    = 104,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  tx,
   output logic                  busy,
   output logic [DEPTH_LOG2:0]   fill,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int BW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0]       BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state_q;
   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   fill_q, fill_d;
   logic [BW-1:0]         baud_q;
   logic [2:0]            bit_q;
   logic [7:0]            shift_q;
   logic                  tx_q, busy_q, ovf_q;
   logic                  push, pop, drop, baud_end;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
   always_comb begin
      pop      = (state_q == IDLE) && (fill_q != '0);
      push     = in_valid && ((fill_q != FULL_CNT) || pop);
      drop     = in_valid && !push;
      baud_end = (baud_q == BAUD_LAST);
      fill_d   = fill_q;
      if (push && !pop) begin
         fill_d = fill_q + 1'b1;
      end else if (pop && !push) begin
         fill_d = fill_q - 1'b1;
      end
   end

   // Storage carries no reset; resetting the pointers and count discards its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ovf_q    <= 1'b0;
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (drop) ovf_q    <= 1'b1;
         fill_q <= fill_d;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  state_q <= START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= DATA;
                  tx_q    <= shift_q[0];
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     state_q <= STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     shift_q <= {1'b0, shift_q[7:1]};
                     tx_q    <= shift_q[1];
                     bit_q   <= bit_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx       = tx_q;
   assign busy     = busy_q;
   assign fill     = fill_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_i2c_byte_uart_tx.sv
// Bench for i2c_byte_uart_tx: a small-config instance checked cycle by cycle against a queue/timer
// model plus frame tables, and a default-rate instance checked by a UART receiver and scoreboard.
module tb_i2c_byte_uart_tx;

   localparam int DIV_A = 4;
   localparam int DL_A = 2;
   localparam int DEPTH_A = 4;
   localparam int DIV_B = 104;
   localparam int DL_B = 3;
   localparam int NB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] in_data_a = '0, in_data_b = '0;
   logic in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic tx_a, busy_a, ovf_a, tx_b, busy_b, ovf_b;
   logic [DL_A:0] fill_a;
   logic [DL_B:0] fill_b;

   always #5 clk = ~clk;

   i2c_byte_uart_tx #(.CLK_DIV(DIV_A), .DEPTH_LOG2(DL_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
      .tx(tx_a), .busy(busy_a), .fill(fill_a), .overflow(ovf_a));

   i2c_byte_uart_tx #(.CLK_DIV(DIV_B), .DEPTH_LOG2(DL_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
      .tx(tx_b), .busy(busy_b), .fill(fill_b), .overflow(ovf_b));

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus a countdown of the cycles left in the current frame.
   logic [7:0] fifo_m[$];
   logic [7:0] m_cur = '0;
   int m_timer = 0;
   logic m_ovf = 1'b0;
   logic m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_m.delete();
         m_timer = 0;
         m_ovf = 1'b0;
      end else begin
         m_pop = (m_timer == 0) && (fifo_m.size() != 0);
         if (m_timer != 0) begin
            m_timer = m_timer - 1;
         end else if (m_pop) begin
            m_cur = fifo_m.pop_front();
            m_timer = 10 * DIV_A;
         end
         if (in_valid_a) begin
            if (fifo_m.size() < DEPTH_A) fifo_m.push_back(in_data_a);
            else m_ovf = 1'b1;
         end
      end
   end

   function automatic logic exp_tx();
      int e, s;
      if (m_timer == 0) return 1'b1;
      e = 10 * DIV_A - m_timer;
      s = e / DIV_A;
      if (s == 0) return 1'b0;
      if (s == 9) return 1'b1;
      return m_cur[s-1];
   endfunction

   logic chk_en = 1'b0;
   int frames_a = 0;
   logic busy_prev = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_tx", 32'(tx_a), 32'(exp_tx()));
         check("cyc_busy", 32'(busy_a), 32'(m_timer != 0));
         check("cyc_fill", 32'(fill_a), 32'(fifo_m.size()));
         check("cyc_ovf", 32'(ovf_a), 32'(m_ovf));
      end
      if (busy_a && !busy_prev) frames_a++;
      busy_prev = busy_a;
   end

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;  // frame[i] is tx during bit slot i (slot 0 = start)
   } vec_t;

   vec_t vecs[5];

   // Caller is 1ns after a posedge; returns 1ns after the sampling posedge.
   task automatic send_a(input logic [7:0] d);
      in_data_a = d;
      in_valid_a = 1'b1;
      @(posedge clk); #1;
      in_valid_a = 1'b0;
   endtask

   task automatic wait_idle_a();
      int t;
      t = 0;
      while ((m_timer != 0 || fifo_m.size() != 0) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      check("idle_timeout", 32'(t < 2000), 32'd1);
   endtask

   task automatic check_frame(input logic [7:0] d, input logic [9:0] frame);
      wait_idle_a();
      send_a(d);
      @(negedge clk);
      check("lat_fill1", 32'(fill_a), 32'd1);
      check("lat_tx_idle", 32'(tx_a), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < DIV_A; k++) begin
            @(negedge clk);
            check("frame_bit", 32'(tx_a), 32'(frame[i]));
            check("frame_busy", 32'(busy_a), 32'd1);
            if (i == 0 && k == 0) check("lat_fill0", 32'(fill_a), 32'd0);
         end
      end
      @(negedge clk);
      check("post_busy", 32'(busy_a), 32'd0);
      check("post_tx", 32'(tx_a), 32'd1);
      @(posedge clk); #1;
   endtask

   // UART receiver for the default-rate instance; samples each bit at its midpoint.
   task automatic rx_b(output logic [7:0] b, output logic ok);
      int t;
      ok = 1'b1;
      b = '0;
      t = 0;
      while (tx_b === 1'b1 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 4000) begin
         ok = 1'b0;
         return;
      end
      for (int c = 0; c < 10 * DIV_B; c++) begin
         if (c % DIV_B == DIV_B / 2) begin
            if (c / DIV_B == 0) check("b_start", 32'(tx_b), 32'd0);
            else if (c / DIV_B <= 8) b[c/DIV_B-1] = tx_b;
            else check("b_stop", 32'(tx_b), 32'd1);
         end
         if (c == 10 * DIV_B - 1) check("b_len_busy", 32'(busy_b), 32'd1);
         @(negedge clk);
      end
      check("b_len_end", 32'(busy_b), 32'd0);
   endtask

   logic [7:0] exp_q[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int peak, t;
      logic [7:0] got;
      logic ok;

      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'h00, 10'b1000000000};
      vecs[2] = '{8'hFF, 10'b1111111110};
      vecs[3] = '{8'h01, 10'b1000000010};
      vecs[4] = '{8'h80, 10'b1100000000};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_fill", 32'(fill_a), 32'd0);
      check("rst_ovf", 32'(ovf_a), 32'd0);
      check("rst_tx_b", 32'(tx_b), 32'd1);
      @(posedge clk); #1;
      chk_en = 1'b1;

      // Single-byte frames, including 0xA5
      for (int v = 0; v < 5; v++) check_frame(vecs[v].data, vecs[v].frame);

      // Three bytes back to back
      wait_idle_a();
      send_a(8'h01);
      send_a(8'h80);
      send_a(8'hFF);
      peak = 0;
      t = 0;
      while ((m_timer != 0 || fifo_m.size() != 0) && t < 2000) begin
         @(negedge clk);
         if (int'(fill_a) > peak) peak = int'(fill_a);
         @(posedge clk); #1;
         t++;
      end
      check("burst_peak", 32'(peak), 32'd2);
      check("burst_ovf", 32'(ovf_a), 32'd0);

      // Push and pop in the same cycle with the FIFO full
      wait_idle_a();
      for (int n = 0; n < 5; n++) send_a(8'(8'h10 + n));
      t = 0;
      while (!(m_timer == 0 && fifo_m.size() == DEPTH_A) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("pp_wait", 32'(t < 200), 32'd1);
      check("pp_full_before", 32'(fill_a), 32'd4);
      send_a(8'h5A);
      @(negedge clk);
      check("pp_fill", 32'(fill_a), 32'd4);
      check("pp_ovf", 32'(ovf_a), 32'd0);
      @(posedge clk); #1;
      wait_idle_a();

      // Six consecutive pushes: the sixth is dropped
      frames_a = 0;
      for (int n = 0; n < 6; n++) send_a(8'($urandom_range(0, 255)));
      @(negedge clk);
      check("ovf_fill", 32'(fill_a), 32'd4);
      check("ovf_flag", 32'(ovf_a), 32'd1);
      @(posedge clk); #1;
      wait_idle_a();
      repeat (2) @(posedge clk);
      #1;
      check("ovf_frames", 32'(frames_a), 32'd5);
      check("ovf_sticky", 32'(ovf_a), 32'd1);

      // Random traffic against the model
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) != 0) send_a(8'($urandom_range(0, 255)));
         else begin @(posedge clk); #1; end
         repeat ($urandom_range(0, 30)) @(posedge clk);
         #1;
      end
      wait_idle_a();

      // Reset in the middle of the data bits
      send_a(8'h00);
      send_a(8'h11);
      send_a(8'h22);
      repeat (9) @(posedge clk);
      #1;
      check("pre_rst_tx", 32'(tx_a), 32'(exp_tx()));
      check("pre_rst_busy", 32'(busy_a), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_tx", 32'(tx_a), 32'd1);
      check("rst_mid_busy", 32'(busy_a), 32'd0);
      check("rst_mid_fill", 32'(fill_a), 32'd0);
      check("rst_mid_ovf", 32'(ovf_a), 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_frame(8'h3C, 10'b1001111000);

      // Default-rate instance: random stream below line rate
      fork
         begin
            for (int n = 0; n < NB; n++) begin
               in_data_b = 8'($urandom_range(0, 255));
               exp_q.push_back(in_data_b);
               in_valid_b = 1'b1;
               @(posedge clk); #1;
               in_valid_b = 1'b0;
               repeat ($urandom_range(600, 1500)) @(posedge clk);
               #1;
            end
         end
         begin
            for (int n = 0; n < NB; n++) begin
               rx_b(got, ok);
               check("b_rx_timeout", 32'(ok), 32'd1);
               if (!ok) break;
               check("b_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) check("b_byte", 32'(got), 32'(exp_q.pop_front()));
            end
         end
      join
      check("b_ovf", 32'(ovf_b), 32'd0);
      check("b_fill", 32'(fill_b), 32'd0);
      check("b_q_drained", 32'(exp_q.size()), 32'd0);

      wait_idle_a();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
